// File: rtl/croc_sram_bank_ctrl_if.sv
// croc_sram_bank_ctrl_if: OBI request/response bundle between the main
// crossbar (master) and the SRAM bank controller (slave).
//   req/gnt            request handshake
//   addr/we/be/wdata   request payload, aid = request ID
//   rvalid/rdata/rid   response, err = error response
interface croc_sram_bank_ctrl_if #(
  parameter int unsigned IdWidth = 3
) ();
  logic               req;
  logic               gnt;
  logic [31:0]        addr;
  logic               we;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic [IdWidth-1:0] aid;
  logic               rvalid;
  logic [31:0]        rdata;
  logic [IdWidth-1:0] rid;
  logic               err;

  modport master (
    output req, addr, we, be, wdata, aid,
    input  gnt, rvalid, rdata, rid, err
  );

  modport slave (
    input  req, addr, we, be, wdata, aid,
    output gnt, rvalid, rdata, rid, err
  );
endinterface

// File: rtl/croc_sram_bank_ctrl.sv
// croc_sram_bank_ctrl: OBI subordinate fronting NumBanks single-port SRAM
// macros. Decodes the byte address into bank/row (contiguous or
// word-interleaved), returns an error response for out-of-range accesses,
// and puts idle banks to sleep with a wake-up stall before the next grant.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   obi            OBI slave port (request, grant, 1-cycle response)
//   bank_req_o     one-hot bank select
//   bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o  shared bank command
//   bank_rdata_i   per-bank read data, valid one cycle after bank_req_o
//   bank_sleep_o   per-bank retention request
module croc_sram_bank_ctrl #(
  parameter int unsigned NumBanks        = 2,
  parameter int unsigned BankNumWords    = 512,
  parameter logic [31:0] BaseAddr        = 32'h1000_0000,
  parameter bit          Interleaved     = 1'b0,
  parameter int unsigned IdWidth         = 3,
  parameter int unsigned SleepIdleCycles = 0,
  parameter int unsigned WakeCycles      = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  croc_sram_bank_ctrl_if.slave            obi,
  output logic [NumBanks-1:0]             bank_req_o,
  output logic                            bank_we_o,
  output logic [$clog2(BankNumWords)-1:0] bank_addr_o,
  output logic [3:0]                      bank_be_o,
  output logic [31:0]                     bank_wdata_o,
  input  logic [NumBanks*32-1:0]          bank_rdata_i,
  output logic [NumBanks-1:0]             bank_sleep_o
);

  localparam int unsigned BAW      = $clog2(BankNumWords);
  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned BIW      = (BankBits == 0) ? 1 : BankBits;
  localparam int unsigned IW       = (SleepIdleCycles == 0) ? 1 : $clog2(SleepIdleCycles + 1);
  localparam int unsigned WW       = $clog2(WakeCycles + 1);
  localparam logic [30:0] RegionWords = 31'(NumBanks) * 31'(BankNumWords);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } bank_state_e;

  // Address decode
  logic [29:0]    word;
  logic           in_range;
  logic [BIW-1:0] bank_sel;
  logic [BAW-1:0] row;

  always_comb begin
    word     = obi.addr[31:2] - BaseAddr[31:2];
    in_range = (obi.addr >= BaseAddr) && ({1'b0, word} < RegionWords);
    // Shifts by constants are plain bit slices; the mask keeps the index
    // inside the bank range even for out-of-range addresses.
    if (Interleaved) begin
      bank_sel = BIW'(word) & BIW'(NumBanks - 1);
      row      = BAW'(word >> BankBits);
    end else begin
      bank_sel = BIW'(word >> BAW) & BIW'(NumBanks - 1);
      row      = BAW'(word);
    end
  end

  // Per-bank power FSMs
  bank_state_e       state_q [NumBanks];
  bank_state_e       state_d [NumBanks];
  logic [IW-1:0]     idle_q  [NumBanks];
  logic [IW-1:0]     idle_d  [NumBanks];
  logic [WW-1:0]     wake_q  [NumBanks];
  logic [WW-1:0]     wake_d  [NumBanks];
  logic [NumBanks-1:0] hit;
  logic [NumBanks-1:0] active;
  logic                gnt;

  always_comb begin
    for (int unsigned b = 0; b < NumBanks; b++) begin
      hit[b]          = obi.req && in_range && (bank_sel == BIW'(b));
      active[b]       = (state_q[b] == ACTIVE);
      bank_sleep_o[b] = (state_q[b] == SLEEP);
      state_d[b]      = state_q[b];
      idle_d[b]       = idle_q[b];
      wake_d[b]       = wake_q[b];
      unique case (state_q[b])
        ACTIVE: begin
          // hit in ACTIVE means granted, which always beats the sleep threshold
          if (hit[b]) begin
            idle_d[b] = '0;
          end else if (SleepIdleCycles != 0) begin
            if (idle_q[b] == IW'(SleepIdleCycles - 1)) begin
              state_d[b] = SLEEP;
              idle_d[b]  = '0;
            end else begin
              idle_d[b] = idle_q[b] + 1'b1;
            end
          end
        end
        SLEEP: begin
          if (hit[b]) begin
            state_d[b] = WAKE;
            wake_d[b]  = WW'(WakeCycles);
          end
        end
        WAKE: begin
          if (wake_q[b] == WW'(1)) begin
            state_d[b] = ACTIVE;
          end else begin
            wake_d[b] = wake_q[b] - 1'b1;
          end
        end
        default: state_d[b] = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < NumBanks; b++) begin
      if (rst_i) begin
        state_q[b] <= ACTIVE;
        idle_q[b]  <= '0;
        wake_q[b]  <= '0;
      end else begin
        state_q[b] <= state_d[b];
        idle_q[b]  <= idle_d[b];
        wake_q[b]  <= wake_d[b];
      end
    end
  end

  // Grant and bank command
  always_comb begin
    gnt          = obi.req && (!in_range || |(hit & active));
    obi.gnt      = gnt;
    bank_req_o   = hit & active;
    bank_we_o    = obi.we;
    bank_addr_o  = row;
    bank_be_o    = obi.be;
    bank_wdata_o = obi.wdata;
  end

  // Response stage
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic               rsp_we_q;
  logic [BIW-1:0]     rsp_bank_q;
  logic [IdWidth-1:0] rsp_id_q;
  logic [31:0]        sel_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_bank_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= gnt;
      if (gnt) begin
        rsp_err_q  <= !in_range;
        rsp_we_q   <= obi.we;
        rsp_bank_q <= bank_sel;
        rsp_id_q   <= obi.aid;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      if (rsp_bank_q == BIW'(b)) sel_rdata = bank_rdata_i[b*32 +: 32];
    end
    obi.rvalid = rsp_valid_q;
    obi.rid    = rsp_id_q;
    obi.err    = rsp_valid_q && rsp_err_q;
    obi.rdata  = '0;
    if (rsp_valid_q) begin
      if (rsp_err_q)      obi.rdata = 32'hBADC_AB1E;
      else if (!rsp_we_q) obi.rdata = sel_rdata;
    end
  end

endmodule

// File: tb/tb_croc_sram_bank_ctrl.sv
// Directed bench for croc_sram_bank_ctrl: a contiguous no-sleep instance
// (dut_c) and an interleaved instance with sleep enabled (dut_s), each
// backed by a small behavioural SRAM model.
module tb_croc_sram_bank_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  localparam logic [31:0] A0 = 32'h1111_0000;
  localparam logic [31:0] A1 = 32'h2222_0001;
  localparam logic [31:0] A2 = 32'h3333_0002;

  croc_sram_bank_ctrl_if #(.IdWidth(3)) obi_c ();
  croc_sram_bank_ctrl_if #(.IdWidth(3)) obi_s ();

  logic [1:0]  c_bank_req,   s_bank_req;
  logic        c_bank_we,    s_bank_we;
  logic [8:0]  c_bank_addr,  s_bank_addr;
  logic [3:0]  c_bank_be,    s_bank_be;
  logic [31:0] c_bank_wdata, s_bank_wdata;
  logic [63:0] c_bank_rdata, s_bank_rdata;
  logic [1:0]  c_bank_sleep, s_bank_sleep;

  croc_sram_bank_ctrl #(
    .NumBanks(2), .BankNumWords(512), .BaseAddr(32'h1000_0000), .Interleaved(1'b0),
    .IdWidth(3), .SleepIdleCycles(0), .WakeCycles(2)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .obi(obi_c),
    .bank_req_o(c_bank_req), .bank_we_o(c_bank_we), .bank_addr_o(c_bank_addr),
    .bank_be_o(c_bank_be), .bank_wdata_o(c_bank_wdata), .bank_rdata_i(c_bank_rdata),
    .bank_sleep_o(c_bank_sleep)
  );

  croc_sram_bank_ctrl #(
    .NumBanks(2), .BankNumWords(512), .BaseAddr(32'h1000_0000), .Interleaved(1'b1),
    .IdWidth(3), .SleepIdleCycles(4), .WakeCycles(2)
  ) dut_s (
    .clk_i(clk), .rst_i(rst), .obi(obi_s),
    .bank_req_o(s_bank_req), .bank_we_o(s_bank_we), .bank_addr_o(s_bank_addr),
    .bank_be_o(s_bank_be), .bank_wdata_o(s_bank_wdata), .bank_rdata_i(s_bank_rdata),
    .bank_sleep_o(s_bank_sleep)
  );

  // SRAM models: one-cycle read latency, byte-masked writes
  logic [31:0] mem_c [0:1][0:511];
  logic [31:0] mem_s [0:1][0:511];
  logic [31:0] rd_c [0:1];
  logic [31:0] rd_s [0:1];

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (c_bank_req[b]) begin
        if (c_bank_we) begin
          for (int k = 0; k < 4; k++)
            if (c_bank_be[k]) mem_c[b][c_bank_addr][k*8 +: 8] <= c_bank_wdata[k*8 +: 8];
        end else rd_c[b] <= mem_c[b][c_bank_addr];
      end
      if (s_bank_req[b]) begin
        if (s_bank_we) begin
          for (int k = 0; k < 4; k++)
            if (s_bank_be[k]) mem_s[b][s_bank_addr][k*8 +: 8] <= s_bank_wdata[k*8 +: 8];
        end else rd_s[b] <= mem_s[b][s_bank_addr];
      end
    end
  end

  assign c_bank_rdata = {rd_c[1], rd_c[0]};
  assign s_bank_rdata = {rd_s[1], rd_s[0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_c(input logic req, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [2:0] aid);
    obi_c.req = req; obi_c.addr = addr; obi_c.we = we; obi_c.wdata = wdata; obi_c.aid = aid;
  endtask

  task automatic drive_s(input logic req, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [2:0] aid);
    obi_s.req = req; obi_s.addr = addr; obi_s.we = we; obi_s.wdata = wdata; obi_s.aid = aid;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    obi_c.be = 4'hF;
    obi_s.be = 4'hF;
    drive_c(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
    drive_s(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
    repeat (3) @(negedge clk);
    #1;
    check("rst c rvalid",     32'(obi_c.rvalid), 32'd0);
    check("rst c err",        32'(obi_c.err),    32'd0);
    check("rst c rdata",      obi_c.rdata,       32'd0);
    check("rst c rid",        32'(obi_c.rid),    32'd0);
    check("rst c bank_req",   32'(c_bank_req),   32'd0);
    check("rst s rvalid",     32'(obi_s.rvalid), 32'd0);
    check("rst s bank_sleep", 32'(s_bank_sleep), 32'd0);

    // Interleaved writes: banks 0,1,0 rows 0,0,1, back-to-back
    @(negedge clk); rst = 1'b0;
    drive_s(1'b1, 32'h1000_0000, 1'b1, A0, 3'd1); #1;
    check("il0 gnt",   32'(obi_s.gnt),   32'd1);
    check("il0 bank",  32'(s_bank_req),  32'd1);
    check("il0 row",   32'(s_bank_addr), 32'd0);
    check("il0 we",    32'(s_bank_we),   32'd1);
    check("il0 wdata", s_bank_wdata,     A0);
    @(negedge clk); drive_s(1'b1, 32'h1000_0004, 1'b1, A1, 3'd2); #1;
    check("il1 rvalid", 32'(obi_s.rvalid), 32'd1);
    check("il1 rid",    32'(obi_s.rid),    32'd1);
    check("il1 gnt",    32'(obi_s.gnt),    32'd1);
    check("il1 bank",   32'(s_bank_req),   32'd2);
    check("il1 row",    32'(s_bank_addr),  32'd0);
    @(negedge clk); drive_s(1'b1, 32'h1000_0008, 1'b1, A2, 3'd3); #1;
    check("il2 rvalid", 32'(obi_s.rvalid), 32'd1);
    check("il2 rid",    32'(obi_s.rid),    32'd2);
    check("il2 bank",   32'(s_bank_req),   32'd1);
    check("il2 row",    32'(s_bank_addr),  32'd1);
    @(negedge clk); drive_s(1'b0, 32'h0, 1'b0, 32'h0, 3'd0); #1;
    check("il3 rvalid", 32'(obi_s.rvalid), 32'd1);
    check("il3 rid",    32'(obi_s.rid),    32'd3);
    check("il3 rdata",  obi_s.rdata,       32'd0);
    check("il3 err",    32'(obi_s.err),    32'd0);
    @(negedge clk); #1;
    check("il4 rvalid", 32'(obi_s.rvalid), 32'd0);

    // Contiguous: write/read back, row boundaries, out-of-range
    @(negedge clk); drive_c(1'b1, 32'h1000_0800, 1'b1, 32'hCAFE_0001, 3'd4); #1;
    check("ct wr gnt",   32'(obi_c.gnt),   32'd1);
    check("ct wr bank",  32'(c_bank_req),  32'd2);
    check("ct wr row",   32'(c_bank_addr), 32'd0);
    check("ct wr we",    32'(c_bank_we),   32'd1);
    check("ct wr wdata", c_bank_wdata,     32'hCAFE_0001);
    @(negedge clk); drive_c(1'b1, 32'h1000_0800, 1'b0, 32'h0, 3'd5); #1;
    check("ct wr rvalid", 32'(obi_c.rvalid), 32'd1);
    check("ct wr rid",    32'(obi_c.rid),    32'd4);
    check("ct wr rdata",  obi_c.rdata,       32'd0);
    check("ct rd gnt",    32'(obi_c.gnt),    32'd1);
    check("ct rd bank",   32'(c_bank_req),   32'd2);
    @(negedge clk); drive_c(1'b1, 32'h1000_0FFC, 1'b0, 32'h0, 3'd6); #1;
    check("ct rd rvalid", 32'(obi_c.rvalid), 32'd1);
    check("ct rd rid",    32'(obi_c.rid),    32'd5);
    check("ct rd rdata",  obi_c.rdata,       32'hCAFE_0001);
    check("ct rd err",    32'(obi_c.err),    32'd0);
    check("ct top bank",  32'(c_bank_req),   32'd2);
    check("ct top row",   32'(c_bank_addr),  32'd511);
    @(negedge clk); drive_c(1'b1, 32'h1000_07FC, 1'b0, 32'h0, 3'd1); #1;
    check("ct b0 bank",   32'(c_bank_req),   32'd1);
    check("ct b0 row",    32'(c_bank_addr),  32'd511);
    @(negedge clk); drive_c(1'b1, 32'h1000_1000, 1'b0, 32'h0, 3'd7); #1;
    check("oor hi gnt",   32'(obi_c.gnt),    32'd1);
    check("oor hi bank",  32'(c_bank_req),   32'd0);
    @(negedge clk); drive_c(1'b1, 32'h0FFF_FFFC, 1'b0, 32'h0, 3'd0); #1;
    check("oor hi err",   32'(obi_c.err),    32'd1);
    check("oor hi rdata", obi_c.rdata,       32'hBADC_AB1E);
    check("oor hi rid",   32'(obi_c.rid),    32'd7);
    check("oor lo gnt",   32'(obi_c.gnt),    32'd1);
    check("oor lo bank",  32'(c_bank_req),   32'd0);
    @(negedge clk); drive_c(1'b0, 32'h0, 1'b0, 32'h0, 3'd0); #1;
    check("oor lo rvalid", 32'(obi_c.rvalid), 32'd1);
    check("oor lo err",    32'(obi_c.err),    32'd1);
    check("oor lo rdata",  obi_c.rdata,       32'hBADC_AB1E);
    @(negedge clk); #1;
    check("oor idle rvalid", 32'(obi_c.rvalid), 32'd0);
    check("oor idle err",    32'(obi_c.err),    32'd0);

    // Reset in the grant cycle drops the response; also restarts dut_s
    @(negedge clk); drive_c(1'b1, 32'h1000_0800, 1'b0, 32'h0, 3'd2); rst = 1'b1; #1;
    check("rstmid gnt", 32'(obi_c.gnt), 32'd1);
    @(negedge clk); drive_c(1'b0, 32'h0, 1'b0, 32'h0, 3'd0); rst = 1'b0;
    drive_s(1'b1, 32'h1000_0004, 1'b0, 32'h0, 3'd1); #1;
    check("rstmid rvalid", 32'(obi_c.rvalid), 32'd0);
    check("sl r0 sleep",   32'(s_bank_sleep), 32'd0);
    @(negedge clk); #1;
    check("rstmid rvalid2", 32'(obi_c.rvalid), 32'd0);
    check("sl b1 rdata",    obi_s.rdata,       A1);
    check("sl b1 rid",      32'(obi_s.rid),    32'd1);
    repeat (2) @(negedge clk); #1;
    check("sl r3 sleep", 32'(s_bank_sleep), 32'd0);
    @(negedge clk); #1;
    check("sl r4 sleep", 32'(s_bank_sleep), 32'd1);
    check("sl r4 gnt",   32'(obi_s.gnt),    32'd1);
    check("sl r4 bank",  32'(s_bank_req),   32'd2);
    @(negedge clk); drive_s(1'b1, 32'h1000_0000, 1'b0, 32'h0, 3'd5); #1;
    check("wk r5 gnt",   32'(obi_s.gnt),    32'd0);
    check("wk r5 sleep", 32'(s_bank_sleep), 32'd1);
    check("wk r5 bank",  32'(s_bank_req),   32'd0);
    @(negedge clk); #1;
    check("wk r6 gnt",    32'(obi_s.gnt),    32'd0);
    check("wk r6 sleep",  32'(s_bank_sleep), 32'd0);
    check("wk r6 rvalid", 32'(obi_s.rvalid), 32'd0);
    @(negedge clk); #1;
    check("wk r7 gnt", 32'(obi_s.gnt), 32'd0);
    @(negedge clk); #1;
    check("wk r8 gnt",   32'(obi_s.gnt),    32'd1);
    check("wk r8 bank",  32'(s_bank_req),   32'd1);
    check("wk r8 sleep", 32'(s_bank_sleep), 32'd0);
    @(negedge clk); drive_s(1'b0, 32'h0, 1'b0, 32'h0, 3'd0); #1;
    check("wk rvalid", 32'(obi_s.rvalid), 32'd1);
    check("wk rid",    32'(obi_s.rid),    32'd5);
    check("wk rdata",  obi_s.rdata,       A0);

    // Reset while bank 0 is in WAKE
    repeat (4) @(negedge clk); #1;
    check("rw sleep both", 32'(s_bank_sleep), 32'd3);
    @(negedge clk); drive_s(1'b1, 32'h1000_0000, 1'b0, 32'h0, 3'd6); #1;
    check("rw gnt0", 32'(obi_s.gnt), 32'd0);
    @(negedge clk); #1;
    check("rw wake sleep", 32'(s_bank_sleep), 32'd2);
    check("rw wake gnt",   32'(obi_s.gnt),    32'd0);
    rst = 1'b1; drive_s(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
    @(negedge clk); rst = 1'b0; drive_s(1'b1, 32'h1000_0000, 1'b0, 32'h0, 3'd7); #1;
    check("rw post gnt",   32'(obi_s.gnt),    32'd1);
    check("rw post bank",  32'(s_bank_req),   32'd1);
    check("rw post sleep", 32'(s_bank_sleep), 32'd0);
    @(negedge clk); drive_s(1'b0, 32'h0, 1'b0, 32'h0, 3'd0); #1;
    check("rw rvalid", 32'(obi_s.rvalid), 32'd1);
    check("rw rid",    32'(obi_s.rid),    32'd7);
    check("rw rdata",  obi_s.rdata,       A0);

    // Sleep disabled: 1000 idle cycles never raise bank_sleep_o
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(negedge clk); #1;
      check("nosleep", 32'(c_bank_sleep), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
